tlb_op_seq: RTL and testbench

//  Sequences TLBP/TLBR/TLBWI/TLBWR for the dual-issue pipeline, sitting between the pms stage, the CP0 TLB registers and the TLB array.

---
 rtl/cp0_tlb_pkg.sv | 55 +++++
 rtl/tlb_rand_idx.sv | 25 ++
 rtl/tlb_op_seq.sv | 194 +++++++++++++++++++
 tb/tb_tlb_op_seq.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_tlb_pkg.sv
// Shared definitions for the CP0 TLB operation sequencer: op encodings,
// CP0 register addresses, 78-bit TLB entry field offsets, size defaults
// and the sequencer state enum.
package cp0_tlb_pkg;

  localparam int TLBNUM_DEF = 16;
  localparam int IDX_W_DEF  = 4;
  localparam int ENTRY_W    = 78;

  // op_type encodings
  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  // CP0 register addresses as {reg[4:0], sel[2:0]}
  localparam logic [7:0] CR_INDEX    = 8'h00;
  localparam logic [7:0] CR_ENTRYLO0 = 8'h10;
  localparam logic [7:0] CR_ENTRYLO1 = 8'h18;
  localparam logic [7:0] CR_ENTRYHI  = 8'h50;

  // Entry layout {VPN2,ASID,G,PFN0,C0,D0,V0,PFN1,C1,D1,V1}: LSB offsets
  localparam int F_V1   = 0;
  localparam int F_D1   = 1;
  localparam int F_C1   = 2;
  localparam int F_PFN1 = 5;
  localparam int F_V0   = 25;
  localparam int F_D0   = 26;
  localparam int F_C0   = 27;
  localparam int F_PFN0 = 30;
  localparam int F_G    = 50;
  localparam int F_ASID = 51;
  localparam int F_VPN2 = 59;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROBE = 3'd1,
    ST_READ  = 3'd2,
    ST_RWB   = 3'd3,
    ST_WRITE = 3'd4,
    ST_PWB   = 3'd5
  } state_t;

  // lo0/lo1 are the EntryLo {PFN,C,D,V} fields, i.e. EntryLo[25:1]
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [18:0] vpn2,
    input logic [7:0]  asid,
    input logic        g,
    input logic [24:0] lo0,
    input logic [24:0] lo1
  );
    return {vpn2, asid, g, lo0, lo1};
  endfunction

endpackage

// File: rtl/tlb_rand_idx.sv
// Free-running random-replacement index for TLBWR: increments every cycle
// and wraps from TLBNUM-1 back to 0.
module tlb_rand_idx #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TLBNUM - 1);

  // counter advances unconditionally once out of reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx <= '0;
    end else if (idx == IDX_LAST) begin
      idx <= '0;
    end else begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/tlb_op_seq.sv
// TLBP/TLBR/TLBWI/TLBWR sequencer between the pms stage, the CP0 TLB
// registers and the TLB array. Optional macro TLB_TLBWR_EN enables the
// random-index counter and a real TLBWR write; without it TLBWR retires as
// a no-op.
//
// Handshake: an op transfers on a rising edge where op_valid & op_ready;
// op_ready is high only in IDLE with no flush, and the requester may hold
// op_valid/op_type/cp0_* until that edge. Operands are captured there and
// never re-sampled.
module tlb_op_seq
  import cp0_tlb_pkg::*;
#(
  parameter int TLBNUM     = TLBNUM_DEF,
  parameter int IDX_W      = IDX_W_DEF,
  parameter int TLB_RD_LAT = 1
) (
  input  logic               cp0_clk,
  input  logic               resetn,
  input  logic               op_valid,
  input  logic [1:0]         op_type,
  output logic               op_ready,
  input  logic               op_flush,
  input  logic [31:0]        cp0_index,
  input  logic [31:0]        cp0_entryhi,
  input  logic [31:0]        cp0_entrylo0,
  input  logic [31:0]        cp0_entrylo1,
  output logic [18:0]        s_vpn2,
  output logic [7:0]         s_asid,
  input  logic               s_found,
  input  logic [IDX_W-1:0]   s_index,
  output logic [IDX_W-1:0]   r_index,
  input  logic [ENTRY_W-1:0] r_data,
  output logic               w_en,
  output logic [IDX_W-1:0]   w_index,
  output logic [ENTRY_W-1:0] w_data,
  output logic               tlbp_we,
  output logic               tlbp_p,
  output logic [IDX_W-1:0]   tlbp_idx,
  output logic               tlbr_we,
  output logic [ENTRY_W-1:0] tlbr_data,
  output logic               busy,
  output logic               done,
  output state_t             dbg_state
);

  localparam int CNT_W = (TLB_RD_LAT > 1) ? $clog2(TLB_RD_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(TLB_RD_LAT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TLBNUM - 1);

  state_t state, nxt;

  logic             accept;
  logic             wr_act;
  logic [IDX_W-1:0] acc_idx;
  logic [1:0]       op_q;
  logic [IDX_W-1:0] idx_q;
  logic [18:0]      vpn2_q;
  logic [7:0]       asid_q;
  logic             g_q;
  logic [24:0]      lo0_q;
  logic [24:0]      lo1_q;
  logic             found_q;
  logic [IDX_W-1:0] hit_q;
  logic [CNT_W-1:0] rd_cnt;
  logic             unused_bits;

  // Index bits above IDX_W, EntryHi[12:8] and EntryLo[31:26] carry no state
  assign unused_bits = ^{cp0_index[31:IDX_W], cp0_entryhi[12:8],
                         cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

  assign accept = op_valid && (state == ST_IDLE) && !op_flush;

`ifdef TLB_TLBWR_EN
  logic [IDX_W-1:0] rnd_idx;

  tlb_rand_idx #(
    .TLBNUM (TLBNUM),
    .IDX_W  (IDX_W)
  ) u_rand (
    .clk    (cp0_clk),
    .resetn (resetn),
    .idx    (rnd_idx)
  );

  assign acc_idx = (op_type == OP_TLBWR) ? rnd_idx : (cp0_index[IDX_W-1:0] & IDX_MAX);
  assign wr_act  = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);
`else
  assign acc_idx = cp0_index[IDX_W-1:0] & IDX_MAX;
  assign wr_act  = (op_q == OP_TLBWI);
`endif

  // state register
  always_ff @(posedge cp0_clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // next-state: a flush in any busy state drops straight back to IDLE
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op_type)
            OP_TLBP: nxt = ST_PROBE;
            OP_TLBR: nxt = ST_READ;
            default: nxt = ST_WRITE;
          endcase
        end
      end
      ST_PROBE: nxt = ST_PWB;
      ST_READ:  if (rd_cnt == RD_LAST) nxt = ST_RWB;
      default:  nxt = ST_IDLE;
    endcase
    if (op_flush && (state != ST_IDLE)) begin
      nxt = ST_IDLE;
    end
  end

  // operand capture at accept, read-latency count, probe result capture
  always_ff @(posedge cp0_clk or negedge resetn) begin
    if (!resetn) begin
      op_q    <= '0;
      idx_q   <= '0;
      vpn2_q  <= '0;
      asid_q  <= '0;
      g_q     <= 1'b0;
      lo0_q   <= '0;
      lo1_q   <= '0;
      found_q <= 1'b0;
      hit_q   <= '0;
      rd_cnt  <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_type;
        idx_q  <= acc_idx;
        vpn2_q <= cp0_entryhi[31:13];
        asid_q <= cp0_entryhi[7:0];
        g_q    <= cp0_entrylo0[0] & cp0_entrylo1[0];
        lo0_q  <= cp0_entrylo0[25:1];
        lo1_q  <= cp0_entrylo1[25:1];
        rd_cnt <= '0;
      end
      if (state == ST_READ) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (state == ST_PROBE) begin
        found_q <= s_found;
        hit_q   <= s_index;
      end
    end
  end

  // strobes and handshake outputs; a flush masks every strobe and done
  always_comb begin
    op_ready = (state == ST_IDLE) && !op_flush;
    busy     = (state != ST_IDLE);
    w_en     = 1'b0;
    tlbp_we  = 1'b0;
    tlbr_we  = 1'b0;
    done     = 1'b0;
    if (!op_flush) begin
      case (state)
        ST_WRITE: begin
          w_en = wr_act;
          done = 1'b1;
        end
        ST_RWB: begin
          tlbr_we = 1'b1;
          done    = 1'b1;
        end
        ST_PWB: begin
          tlbp_we = 1'b1;
          done    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s_vpn2    = vpn2_q;
  assign s_asid    = asid_q;
  assign r_index   = idx_q;
  assign w_index   = idx_q;
  assign w_data    = pack_entry(vpn2_q, asid_q, g_q, lo0_q, lo1_q);
  assign tlbp_p    = ~found_q;
  assign tlbp_idx  = found_q ? hit_q : '0;
  assign tlbr_data = r_data;
  assign dbg_state = state;

endmodule

// File: tb/tb_tlb_op_seq.sv
// Directed bench for tlb_op_seq: table of ops with hand-derived results,
// a small behavioural TLB array, and hand-written multi-cycle sequences.
module tb_tlb_op_seq;
  import cp0_tlb_pkg::*;

  // clock / reset
  logic cp0_clk = 1'b0;
  always #5 cp0_clk = ~cp0_clk;
  logic resetn;

  logic        op_valid, op_ready, op_flush;
  logic [1:0]  op_type;
  logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
  logic [18:0] s_vpn2;
  logic [7:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index, r_index, w_index, tlbp_idx;
  logic [77:0] r_data, w_data, tlbr_data;
  logic        w_en, tlbp_we, tlbp_p, tlbr_we, busy, done;
  state_t      dbg_state;

  tlb_op_seq dut (
    .cp0_clk(cp0_clk), .resetn(resetn), .op_valid(op_valid), .op_type(op_type),
    .op_ready(op_ready), .op_flush(op_flush), .cp0_index(cp0_index),
    .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
    .r_index(r_index), .r_data(r_data), .w_en(w_en), .w_index(w_index), .w_data(w_data),
    .tlbp_we(tlbp_we), .tlbp_p(tlbp_p), .tlbp_idx(tlbp_idx), .tlbr_we(tlbr_we),
    .tlbr_data(tlbr_data), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // behavioural TLB: registered read port (latency 1), combinational search
  logic [77:0] tlb [16];
  logic        ld_en;
  logic [3:0]  ld_idx;
  logic [77:0] ld_data;

  always @(posedge cp0_clk) begin
    if (ld_en) tlb[ld_idx] <= ld_data;
    else if (w_en) tlb[w_index] <= w_data;
    r_data <= tlb[r_index];
  end

  always_comb begin
    s_found = 1'b0;
    s_index = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (tlb[i][77:59] == s_vpn2 && (tlb[i][50] || tlb[i][58:51] == s_asid)) begin
        s_found = 1'b1;
        s_index = 4'(i);
      end
    end
  end

`ifdef TLB_TLBWR_EN
  logic [3:0] rnd;
  always @(posedge cp0_clk or negedge resetn) begin
    if (!resetn) rnd <= 4'd0;
    else rnd <= rnd + 4'd1;
  end
`endif

  function automatic logic [77:0] pre_entry(input int i);
    if (i == 5) return {19'h00201, 8'h05, 1'b0, 50'h1_2345_6789};
    return {19'h7FF00 + 19'(i), 8'h00, 1'b0, 50'(i * 3)};
  endfunction

  function automatic logic [77:0] pack(input logic [31:0] ehi, lo0, lo1);
    return {ehi[31:13], ehi[7:0], lo0[0] & lo1[0], lo0[25:6], lo0[5:3], lo0[2], lo0[1],
            lo1[25:6], lo1[5:3], lo1[2], lo1[1]};
  endfunction

  typedef struct {
    int done_cyc; int n_done; int n_wen; logic [3:0] widx; logic [77:0] wdata;
    int n_pwe; logic p; logic [3:0] pidx; int n_rwe; logic [77:0] rdata; int n_multi;
  } cap_t;

  typedef struct {
    string name; logic [1:0] op; logic [31:0] idx, ehi, lo0, lo1; int flush_cyc;
    int exp_cyc; int exp_wen; logic [3:0] exp_widx; logic [77:0] exp_wdata;
    int exp_pwe; logic exp_p; logic [3:0] exp_pidx; int exp_rwe; logic [77:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic [1:0] op,
    input logic [31:0] idx, ehi, lo0, lo1, input int flush_cyc, exp_cyc, exp_wen,
    input logic [3:0] exp_widx, input logic [77:0] exp_wdata, input int exp_pwe,
    input logic exp_p, input logic [3:0] exp_pidx, input int exp_rwe,
    input logic [77:0] exp_rdata);
    vec_t v;
    v.name = name; v.op = op; v.idx = idx; v.ehi = ehi; v.lo0 = lo0; v.lo1 = lo1;
    v.flush_cyc = flush_cyc; v.exp_cyc = exp_cyc; v.exp_wen = exp_wen;
    v.exp_widx = exp_widx; v.exp_wdata = exp_wdata; v.exp_pwe = exp_pwe;
    v.exp_p = exp_p; v.exp_pidx = exp_pidx; v.exp_rwe = exp_rwe; v.exp_rdata = exp_rdata;
    vecs.push_back(v);
  endfunction

  // driver: issue one op, scramble CP0 inputs after accept, observe 8 cycles
  task automatic run_op(input logic [1:0] op, input logic [31:0] idx, ehi, lo0, lo1,
                        input int flush_cyc, output cap_t c);
    int waited;
    int nstb;
    c = '{default: 0};
    c.done_cyc = -1;
    @(negedge cp0_clk);
    op_type = op; cp0_index = idx; cp0_entryhi = ehi;
    cp0_entrylo0 = lo0; cp0_entrylo1 = lo1; op_valid = 1'b1;
    waited = 0;
    while (!op_ready && waited < 20) begin
      @(negedge cp0_clk);
      waited++;
    end
    chk("accept_ready", op_ready, 1'b1);
    @(posedge cp0_clk);
    #1;
    op_valid = 1'b0;
    cp0_index = $urandom; cp0_entryhi = $urandom;
    cp0_entrylo0 = $urandom; cp0_entrylo1 = $urandom;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      op_flush = (cyc == flush_cyc);
      @(negedge cp0_clk);
      nstb = int'(w_en) + int'(tlbp_we) + int'(tlbr_we);
      if (nstb > 1) c.n_multi++;
      if (done) begin
        c.n_done++;
        if (c.done_cyc < 0) c.done_cyc = cyc;
      end
      if (w_en) begin c.n_wen++; c.widx = w_index; c.wdata = w_data; end
      if (tlbp_we) begin c.n_pwe++; c.p = tlbp_p; c.pidx = tlbp_idx; end
      if (tlbr_we) begin c.n_rwe++; c.rdata = tlbr_data; end
      @(posedge cp0_clk);
      #1;
    end
    op_flush = 1'b0;
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] lo0a, lo1a, lo0b, lo1b;
    logic [77:0] e3, e9;
    cap_t c;
    int waited;
    int nstb;

    resetn = 1'b0; op_valid = 1'b0; op_type = 2'b00; op_flush = 1'b0;
    cp0_index = '0; cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;

    // preload TLB while in reset
    for (int i = 0; i < 16; i++) begin
      @(negedge cp0_clk);
      ld_en = 1'b1; ld_idx = 4'(i); ld_data = pre_entry(i);
    end
    @(negedge cp0_clk);
    ld_en = 1'b0;

    chk("rst_op_ready", op_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_w_en", w_en, 1'b0);
    chk("rst_tlbp_we", tlbp_we, 1'b0);
    chk("rst_tlbr_we", tlbr_we, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);
    resetn = 1'b1;
    @(negedge cp0_clk);
    chk("post_rst_ready", op_ready, 1'b1);

    lo0a = {6'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1, 1'b1};
    lo1a = {6'b0, 20'h12345, 3'd2, 1'b0, 1'b1, 1'b0};
    lo0b = {6'b0, 20'h00F0F, 3'd7, 1'b1, 1'b0, 1'b1};
    lo1b = {6'h3F, 20'hFFFFF, 3'd0, 1'b0, 1'b0, 1'b1};
    e3 = pack(32'h1234_6078, lo0a, lo1a);
    e9 = pack(32'h0ABC_1F33, lo0b, lo1b);

    //   name         op        idx           ehi           lo0   lo1   fl cyc wen widx wdata pwe p  pidx rwe rdata
    add("tlbp_hit",   OP_TLBP,  32'd0,        32'h0040_2005, 0,   0,    0, 2,  0, 0, 0,  1, 0, 5, 0, 0);
    add("tlbp_miss",  OP_TLBP,  32'd0,        32'h0080_4007, 0,   0,    0, 2,  0, 0, 0,  1, 1, 0, 0, 0);
    add("tlbwi_3",    OP_TLBWI, 32'd3,        32'h1234_6078, lo0a, lo1a, 0, 1,  1, 3, e3, 0, 0, 0, 0, 0);
    add("tlbr_3",     OP_TLBR,  32'd3,        32'h0,         0,   0,    0, 2,  0, 0, 0,  0, 0, 0, 1, e3);
    add("tlbwi_trunc",OP_TLBWI, 32'hFFFF_FFF9, 32'h0ABC_1F33, lo0b, lo1b, 0, 1, 1, 9, e9, 0, 0, 0, 0, 0);
    add("tlbr_9",     OP_TLBR,  32'h8000_0009, 32'h0,        0,   0,    0, 2,  0, 0, 0,  0, 0, 0, 1, e9);
    add("tlbr_5",     OP_TLBR,  32'd5,        32'h0,         0,   0,    0, 2,  0, 0, 0,  0, 0, 0, 1, pre_entry(5));
    add("tlbp_hit3",  OP_TLBP,  32'd0,        32'h1234_6078, 0,   0,    0, 2,  0, 0, 0,  1, 0, 3, 0, 0);
    add("tlbp_glob9", OP_TLBP,  32'd0,        32'h0ABC_0044, 0,   0,    0, 2,  0, 0, 0,  1, 0, 9, 0, 0);
    add("tlbp_asid",  OP_TLBP,  32'd0,        32'h1234_6079, 0,   0,    0, 2,  0, 0, 0,  1, 1, 0, 0, 0);
    add("flush_read", OP_TLBR,  32'd3,        32'h0,         0,   0,    1, -1, 0, 0, 0,  0, 0, 0, 0, 0);
    add("flush_write",OP_TLBWI, 32'd7,        32'h1111_1011, lo0a, lo1a, 1, -1, 0, 0, 0, 0, 0, 0, 0, 0);
    add("flush_pwb",  OP_TLBP,  32'd0,        32'h0040_2005, 0,   0,    2, -1, 0, 0, 0,  0, 0, 0, 0, 0);
`ifndef TLB_TLBWR_EN
    add("tlbwr_noop", OP_TLBWR, 32'd4,        32'h2222_2022, lo0a, lo1a, 0, 1,  0, 0, 0,  0, 0, 0, 0, 0);
`endif

    foreach (vecs[k]) begin
      run_op(vecs[k].op, vecs[k].idx, vecs[k].ehi, vecs[k].lo0, vecs[k].lo1,
             vecs[k].flush_cyc, c);
      chk({vecs[k].name, "_done_cyc"}, 80'(c.done_cyc), 80'(vecs[k].exp_cyc));
      chk({vecs[k].name, "_n_done"}, 80'(c.n_done), (vecs[k].exp_cyc < 0) ? 80'd0 : 80'd1);
      chk({vecs[k].name, "_n_wen"}, 80'(c.n_wen), 80'(vecs[k].exp_wen));
      chk({vecs[k].name, "_n_pwe"}, 80'(c.n_pwe), 80'(vecs[k].exp_pwe));
      chk({vecs[k].name, "_n_rwe"}, 80'(c.n_rwe), 80'(vecs[k].exp_rwe));
      chk({vecs[k].name, "_multi"}, 80'(c.n_multi), 80'd0);
      if (vecs[k].exp_wen > 0) begin
        chk({vecs[k].name, "_widx"}, c.widx, vecs[k].exp_widx);
        chk({vecs[k].name, "_wdata"}, c.wdata, vecs[k].exp_wdata);
      end
      if (vecs[k].exp_pwe > 0) begin
        chk({vecs[k].name, "_p"}, c.p, vecs[k].exp_p);
        chk({vecs[k].name, "_pidx"}, c.pidx, vecs[k].exp_pidx);
      end
      if (vecs[k].exp_rwe > 0) begin
        chk({vecs[k].name, "_rdata"}, c.rdata, vecs[k].exp_rdata);
      end
    end
    chk("wdata_g_clear", e3[50], 1'b0);
    chk("tlb7_untouched", tlb[7], pre_entry(7));
    chk("tlb5_untouched", tlb[5], pre_entry(5));

    // back-to-back: TLBWI then TLBP accepted the cycle after done
    @(negedge cp0_clk);
    op_valid = 1'b1; op_type = OP_TLBWI; cp0_index = 32'd2;
    cp0_entryhi = 32'h0100_0000; cp0_entrylo0 = lo0a; cp0_entrylo1 = lo1a;
    @(posedge cp0_clk);
    #1;
    op_type = OP_TLBP; cp0_entryhi = 32'h0040_2005;
    @(negedge cp0_clk);
    chk("b2b_ready_low", op_ready, 1'b0);
    chk("b2b_w_en", w_en, 1'b1);
    chk("b2b_done", done, 1'b1);
    chk("b2b_vpn2_held", w_data[77:59], 19'h00800);
    @(negedge cp0_clk);
    chk("b2b_ready_high", op_ready, 1'b1);
    chk("b2b_idle", busy, 1'b0);
    @(posedge cp0_clk);
    #1;
    op_valid = 1'b0;
    @(negedge cp0_clk);
    chk("b2b_probe_state", dbg_state, ST_PROBE);
    @(negedge cp0_clk);
    chk("b2b_tlbp_we", tlbp_we, 1'b1);
    chk("b2b_tlbp_idx", tlbp_idx, 4'd5);
    chk("b2b_tlbp_p", tlbp_p, 1'b0);

    // flush in IDLE blocks acceptance
    @(negedge cp0_clk);
    op_valid = 1'b1; op_type = OP_TLBR; op_flush = 1'b1;
    #1;
    chk("idle_flush_ready", op_ready, 1'b0);
    @(posedge cp0_clk);
    #1;
    op_valid = 1'b0; op_flush = 1'b0;
    @(negedge cp0_clk);
    chk("idle_flush_busy", busy, 1'b0);

`ifdef TLB_TLBWR_EN
    // TLBWR with counter at 15, then a second TLBWR after the wrap
    @(negedge cp0_clk);
    waited = 0;
    while (rnd != 4'd15 && waited < 40) begin
      @(negedge cp0_clk);
      waited++;
    end
    chk("wr_align", rnd, 4'd15);
    op_valid = 1'b1; op_type = OP_TLBWR; cp0_index = 32'd4;
    cp0_entryhi = 32'h0300_0000; cp0_entrylo0 = lo0a; cp0_entrylo1 = lo1a;
    @(posedge cp0_clk);
    #1;
    @(negedge cp0_clk);
    chk("tlbwr_w_en", w_en, 1'b1);
    chk("tlbwr_w_index15", w_index, 4'd15);
    chk("tlbwr_done", done, 1'b1);
    @(posedge cp0_clk);
    #1;
    @(posedge cp0_clk);
    #1;
    op_valid = 1'b0;
    @(negedge cp0_clk);
    chk("tlbwr2_w_en", w_en, 1'b1);
    chk("tlbwr2_wrapped_idx", w_index, 4'd1);
`endif

    // async reset in the middle of a write cycle
    @(negedge cp0_clk);
    op_valid = 1'b1; op_type = OP_TLBWI; cp0_index = 32'd11;
    cp0_entryhi = 32'h0200_0000; cp0_entrylo0 = lo0a; cp0_entrylo1 = lo1a;
    @(posedge cp0_clk);
    #1;
    op_valid = 1'b0;
    @(negedge cp0_clk);
    chk("arst_pre_w_en", w_en, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_w_en_drop", w_en, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_state", dbg_state, ST_IDLE);
    @(negedge cp0_clk);
    resetn = 1'b1;
    nstb = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge cp0_clk);
      nstb += int'(w_en) + int'(tlbp_we) + int'(tlbr_we) + int'(done);
    end
    chk("arst_no_strobe", 80'(nstb), 80'd0);
    chk("arst_tlb11", tlb[11], pre_entry(11));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
